// File: rtl/alu_unit.sv
// alu_unit: RV32I integer execution stage; one-cycle registered result onto the ALU CDB
// plus branch/jump resolution for the ROB.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_TAG_WIDTH
`define ROB_TAG_WIDTH 4
`endif
`ifndef INSIDE_OPCODE_WIDTH
`define INSIDE_OPCODE_WIDTH 6
`endif
`ifndef ZERO_TAG_ROB
`define ZERO_TAG_ROB 4'd0
`endif
`ifndef NOP
`define NOP   6'd0
`define LUI   6'd1
`define AUIPC 6'd2
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define LB    6'd11
`define LH    6'd12
`define LW    6'd13
`define LBU   6'd14
`define LHU   6'd15
`define SB    6'd16
`define SH    6'd17
`define SW    6'd18
`define ADDI  6'd19
`define SLTI  6'd20
`define SLTIU 6'd21
`define XORI  6'd22
`define ORI   6'd23
`define ANDI  6'd24
`define SLLI  6'd25
`define SRLI  6'd26
`define SRAI  6'd27
`define ADD   6'd28
`define SUB   6'd29
`define SLL   6'd30
`define SLT   6'd31
`define SLTU  6'd32
`define XOR   6'd33
`define SRL   6'd34
`define SRA   6'd35
`define OR    6'd36
`define AND   6'd37
`endif

module alu_unit (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy,
    input  logic [`INSIDE_OPCODE_WIDTH-1:0] in_rs_op,
    input  logic [`DATA_WIDTH-1:0]          in_rs_value1,
    input  logic [`DATA_WIDTH-1:0]          in_rs_value2,
    input  logic [`DATA_WIDTH-1:0]          in_rs_imm,
    input  logic [`DATA_WIDTH-1:0]          in_rs_pc,
    input  logic [`ROB_TAG_WIDTH-1:0]       in_rs_rob_tag,
    input  logic                            in_rob_misbranch,
    output logic [`ROB_TAG_WIDTH-1:0]       out_cdb_tag,
    output logic [`DATA_WIDTH-1:0]          out_cdb_value,
    output logic                            out_rob_jump_flag,
    output logic [`DATA_WIDTH-1:0]          out_rob_target_pc
);
    logic [`DATA_WIDTH-1:0] a, b, v2, pc4, pc_imm, res, tgt;
    logic ok, jmp, br;
    assign a = in_rs_value1;
    assign v2 = in_rs_value2;
    // I-type ops reuse the R-type datapath with the immediate as second operand
    assign b = (in_rs_op >= `ADDI && in_rs_op <= `SRAI) ? in_rs_imm : v2;
    assign pc4 = in_rs_pc + 32'd4;
    assign pc_imm = in_rs_pc + in_rs_imm;
    always_comb begin
        ok = 1'b1;
        jmp = 1'b0;
        br = 1'b0;
        res = '0;
        tgt = pc4;
        case (in_rs_op)
            `ADD, `ADDI:   res = a + b;
            `SUB:          res = a - b;
            `AND, `ANDI:   res = a & b;
            `OR, `ORI:     res = a | b;
            `XOR, `XORI:   res = a ^ b;
            `SLT, `SLTI:   res = {31'd0, $signed(a) < $signed(b)};
            `SLTU, `SLTIU: res = {31'd0, a < b};
            `SLL, `SLLI:   res = a << b[4:0];
            `SRL, `SRLI:   res = a >> b[4:0];
            `SRA, `SRAI:   res = 32'($signed(a) >>> b[4:0]);
            `LUI:          res = in_rs_imm;
            `AUIPC:        res = pc_imm;
            `JAL:          begin res = pc4; jmp = 1'b1; tgt = pc_imm; end
            `JALR:         begin res = pc4; jmp = 1'b1; tgt = (a + in_rs_imm) & ~32'd1; end
            `BEQ:          begin br = 1'b1; jmp = a == v2; end
            `BNE:          begin br = 1'b1; jmp = a != v2; end
            `BLT:          begin br = 1'b1; jmp = $signed(a) < $signed(v2); end
            `BGE:          begin br = 1'b1; jmp = $signed(a) >= $signed(v2); end
            `BLTU:         begin br = 1'b1; jmp = a < v2; end
            `BGEU:         begin br = 1'b1; jmp = a >= v2; end
            default:       ok = 1'b0;
        endcase
        if (br && jmp) tgt = pc_imm;
    end

    always_ff @(posedge clk) begin
        if (rst || (rdy && in_rob_misbranch)) begin
            out_cdb_tag <= `ZERO_TAG_ROB;
            out_cdb_value <= '0;
            out_rob_jump_flag <= 1'b0;
            out_rob_target_pc <= '0;
        end else if (rdy) begin
            out_cdb_tag <= ok ? in_rs_rob_tag : `ZERO_TAG_ROB;
            out_rob_jump_flag <= ok && jmp;
            if (ok) begin
                out_cdb_value <= res;
                out_rob_target_pc <= tgt;
            end
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit with immediate-assertion checks.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_TAG_WIDTH
`define ROB_TAG_WIDTH 4
`endif
`ifndef INSIDE_OPCODE_WIDTH
`define INSIDE_OPCODE_WIDTH 6
`endif
`ifndef ZERO_TAG_ROB
`define ZERO_TAG_ROB 4'd0
`endif

module tb_alu_unit;
    localparam logic [5:0] NOP = 6'd0, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4, BEQ = 6'd5,
        BNE = 6'd6, BLT = 6'd7, BGE = 6'd8, LW = 6'd13, ADDI = 6'd19, XORI = 6'd22,
        SRAI = 6'd27, ADD = 6'd28, SUB = 6'd29, SLT = 6'd31, SLTU = 6'd32, SRL = 6'd34,
        SRA = 6'd35;

    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, misb = 1'b0;
    logic [5:0] op = NOP;
    logic [31:0] v1 = '0, v2 = '0, imm = '0, pc = '0, value, target;
    logic [3:0] tag_in = '0, tag;
    logic jump;
    int n = 0, errs = 0;

    always #5 clk = ~clk;

    alu_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_rs_op(op), .in_rs_value1(v1),
        .in_rs_value2(v2), .in_rs_imm(imm), .in_rs_pc(pc), .in_rs_rob_tag(tag_in),
        .in_rob_misbranch(misb), .out_cdb_tag(tag), .out_cdb_value(value),
        .out_rob_jump_flag(jump), .out_rob_target_pc(target)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
        op = o; v1 = a; v2 = b; imm = i; pc = p; tag_in = t;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [3:0] et, input logic [31:0] ev,
                           input logic ej, input logic [31:0] ep);
        chk({name, ".tag"}, 32'(tag), 32'(et));
        chk({name, ".value"}, value, ev);
        chk({name, ".jump"}, 32'(jump), 32'(ej));
        chk({name, ".target"}, target, ep);
    endtask

    initial begin
        issue(ADD, 32'd1, 32'd2, 0, 0, 4'd3);
        tick; chk_all("reset0", 0, 0, 0, 0);
        tick; chk_all("reset1", 0, 0, 0, 0);
        rst = 1'b0;

        issue(ADD, 32'hFFFF_FFFF, 32'd1, 0, 32'h40, 4'd3);
        tick; chk_all("add_wrap", 3, 0, 0, 32'h44);
        issue(SRA, 32'h8000_0000, 32'h24, 0, 0, 4'd4);
        tick; chk_all("sra", 4, 32'hF800_0000, 0, 4);
        issue(SLTU, 32'd1, 32'hFFFF_FFFF, 0, 0, 4'd5);
        tick; chk_all("sltu", 5, 1, 0, 4);
        issue(SLT, 32'd1, 32'hFFFF_FFFF, 0, 0, 4'd6);
        tick; chk_all("slt", 6, 0, 0, 4);
        issue(SRL, 32'h8000_0000, 32'h24, 0, 0, 4'd2);
        tick; chk_all("srl", 2, 32'h0800_0000, 0, 4);
        issue(SUB, 32'd3, 32'd5, 0, 0, 4'd2);
        tick; chk_all("sub", 2, 32'hFFFF_FFFE, 0, 4);
        issue(SRAI, 32'h8000_0000, 32'h0, 32'h1F, 0, 4'd2);
        tick; chk_all("srai", 2, 32'hFFFF_FFFF, 0, 4);
        issue(XORI, 32'h0F0F_0F0F, 32'hDEAD, 32'hFFFF_FFFF, 0, 4'd2);
        tick; chk_all("xori", 2, 32'hF0F0_F0F0, 0, 4);
        issue(AUIPC, 0, 0, 32'h0001_0000, 32'h100, 4'd2);
        tick; chk_all("auipc", 2, 32'h0001_0100, 0, 32'h104);

        issue(BLT, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd6);
        tick; chk_all("blt", 6, 0, 1, 32'h120);
        issue(BGE, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd6);
        tick; chk_all("bge", 6, 0, 0, 32'h104);
        issue(BEQ, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h100, 4'd1);
        tick; chk_all("beq", 1, 0, 1, 32'hF0);
        issue(BNE, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h100, 4'd1);
        tick; chk_all("bne", 1, 0, 0, 32'h104);
        issue(JALR, 32'h1001, 0, 32'd2, 32'h200, 4'd2);
        tick; chk_all("jalr", 2, 32'h204, 1, 32'h1002);
        issue(JAL, 0, 0, 32'h10, 32'h300, 4'd3);
        tick; chk_all("jal", 3, 32'h304, 1, 32'h310);

        issue(ADD, 32'd2, 32'd3, 0, 0, 4'd5); misb = 1'b1;
        tick; chk_all("misbranch", 0, 0, 0, 0);
        misb = 1'b0;
        tick; chk_all("after_flush", 5, 5, 0, 4);

        issue(ADDI, 32'd8, 32'd99, 32'd8, 0, 4'd7);
        tick; chk_all("addi", 7, 32'h10, 0, 4);
        rdy = 1'b0; issue(ADD, 32'd1, 32'd1, 0, 0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            tick; chk_all("stall", 7, 32'h10, 0, 4);
        end
        rdy = 1'b1; issue(NOP, 0, 0, 0, 0, 4'd2);
        tick; chk("nop.tag", 32'(tag), 0);

        issue(ADD, 32'd1, 32'd0, 0, 0, 4'd1);
        tick; chk("b2b1.tag", 32'(tag), 1); chk("b2b1.value", value, 1);
        issue(ADD, 32'd2, 32'd0, 0, 0, 4'd2);
        tick; chk("b2b2.tag", 32'(tag), 2); chk("b2b2.value", value, 2);
        issue(LW, 32'd9, 32'd9, 0, 0, 4'd4);
        tick; chk("b2b_lw.tag", 32'(tag), 0); chk("b2b_lw.jump", 32'(jump), 0);
        issue(ADD, 32'd3, 32'd0, 0, 0, 4'd3);
        tick; chk("b2b3.tag", 32'(tag), 3); chk("b2b3.value", value, 3);
        issue(JAL, 0, 0, 32'h8, 32'h40, 4'd0);
        tick; chk("zero_tag.tag", 32'(tag), 0); chk("zero_tag.value", value, 32'h44);
        issue(NOP, 0, 0, 0, 0, 0);
        tick; chk("idle.tag", 32'(tag), 0); chk("idle.jump", 32'(jump), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Execution stage directly downstream of the reservation station.
- Takes one issued entry per cycle (opcode, operands, immediate, PC, ROB tag) and computes the RV32I integer result.
- Broadcasts the result on the ALU CDB, which feeds the RS, the LSB and the ROB.
- Reports branch/jump resolution (taken flag, target PC) to the ROB.
- Registered output, one-cycle latency, flushed on misbranch.

Parameters:
- None. Widths come from the shared constant macros: `DATA_WIDTH` (32), `ROB_TAG_WIDTH`, `INSIDE_OPCODE_WIDTH`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global ready; low = freeze all state
- in_rs_op  in  `INSIDE_OPCODE_WIDTH`  issued opcode; `NOP` = no work
- in_rs_value1  in  `DATA_WIDTH`  rs1 value
- in_rs_value2  in  `DATA_WIDTH`  rs2 value
- in_rs_imm  in  `DATA_WIDTH`  sign-extended immediate
- in_rs_pc  in  `DATA_WIDTH`  instruction PC
- in_rs_rob_tag  in  `ROB_TAG_WIDTH`  destination ROB entry
- in_rob_misbranch  in  1  flush request from ROB
- out_cdb_tag  out  `ROB_TAG_WIDTH`  result tag; `ZERO_TAG_ROB` = invalid
- out_cdb_value  out  `DATA_WIDTH`  result value
- out_rob_jump_flag  out  1  branch/jump taken
- out_rob_target_pc  out  `DATA_WIDTH`  next PC for control-flow ops

Behaviour:
- All outputs are registers updated on posedge clk.
- Reset (rst=1): out_cdb_tag=`ZERO_TAG_ROB`, out_cdb_value=0, out_rob_jump_flag=0, out_rob_target_pc=0. Reset dominates rdy and misbranch.
- rdy=0: all output registers hold. An input presented that cycle is not consumed; the RS is frozen by the same rdy.
- Misbranch (rdy=1, in_rob_misbranch=1): outputs are driven to their reset values and the input is dropped, even if its op is valid.
- Normal (rdy=1, no misbranch):
  - Default each cycle is tag=`ZERO_TAG_ROB`, jump_flag=0. A result is therefore valid for exactly one cycle.
  - If in_rs_op != `NOP` and it is an ALU op, then next cycle: tag=in_rs_rob_tag, plus value, flag and target as below.
- Latency: input in cycle N -> outputs valid throughout cycle N+1. Back-to-back input every cycle is accepted with no bubble.
- Arithmetic: 32-bit wraparound. Signed compares use $signed; unsigned compares are plain.
  - Shift amount is value2[4:0] (R-type) or imm[4:0] (I-type).
  - SRA/SRAI are arithmetic; SRL/SRLI are logical.
- Op results (v1=value1, v2=value2):
  - ADD v1+v2; SUB v1-v2; AND/OR/XOR bitwise.
  - SLT/SLTU: 1 or 0 from v1<v2 (signed / unsigned).
  - SLL/SRL/SRA: shift v1 by v2[4:0].
  - ADDI/ANDI/ORI/XORI/SLTI/SLTIU/SLLI/SRLI/SRAI: same operations with imm in place of v2.
  - LUI: value=imm.
  - AUIPC: value=pc+imm.
  - JAL: value=pc+4, jump_flag=1, target=pc+imm.
  - JALR: value=pc+4, jump_flag=1, target=(v1+imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: value=0, jump_flag=condition, target = taken ? pc+imm : pc+4.
  - Non-control ops: jump_flag=0, target=pc+4.
- Non-ALU opcodes (loads/stores, unknown): treated as `NOP`; tag stays `ZERO_TAG_ROB`.
- Input tag `ZERO_TAG_ROB` with a valid op: computed but emitted with tag zero, i.e. invisible.
- No internal buffering. The CDB is owned exclusively by this unit, so there is no backpressure.

Test Plan:
- Reset: assert rst 2 cycles with in_rs_op=ADD -> out_cdb_tag=0, value=0, jump_flag=0, target=0 throughout.
- ALU ops: ADD v1=0xFFFFFFFF v2=1 tag=3 -> cycle+1 tag=3 value=0. SRA v1=0x80000000 v2=0x24 -> 0xF8000000. SLTU v1=1 v2=0xFFFFFFFF -> 1. SLT with same operands -> 0.
- Control flow:
  - BLT pc=0x100 imm=0x20 v1=-1 v2=0 -> jump_flag=1, target=0x120.
  - BGE with same operands -> jump_flag=0, target=0x104.
  - JALR pc=0x200 v1=0x1001 imm=2 -> value=0x204, target=0x1002.
- Misbranch: issue ADD tag=5 with in_rob_misbranch=1 -> next-cycle tag=0. Issue next cycle without flush -> result appears normally.
- rdy stall: issue ADDI tag=7 (result 0x10) -> valid cycle+1. Drop rdy for 3 cycles -> tag=7/0x10 held. Raise rdy with `NOP` input -> tag returns to 0 next cycle.
- Back-to-back: ops with tags 1,2,3 on consecutive cycles -> tags 1,2,3 on consecutive cycles, no gaps. A `LW` opcode interleaved -> tag=0 in its slot.
